// File: rtl/clock_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_ctrl
// Brief    : Run-time programmable clock/strobe generator with glitch-free
//            start/stop and divisor changes applied on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gen_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_div_valid,
    output logic                 o_div_ready,
    output logic                 o_clk,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_running
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] active_div;
    logic [DIV_WIDTH-1:0] pending_div;
    logic                 pending;

    logic                 cnt_nonzero;
    logic                 at_boundary;
    logic                 accept;
    logic [DIV_WIDTH-1:0] load_value;

    logic                 do_rise;
    logic                 do_fall;
    logic                 do_apply;
    logic                 do_load;
    logic                 do_dec;

    assign cnt_nonzero = (cnt != '0);
    assign at_boundary = (state == ST_RUN) && !cnt_nonzero && !o_clk;
    assign accept      = i_div_valid && o_div_ready;

    // A divisor applied in this cycle is also the one loaded for the new phase.
    assign load_value  = do_apply ? pending_div : active_div;

    assign o_div_ready = ~pending;
    assign o_running   = (state == ST_RUN);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (at_boundary && !i_enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-cycle datapath actions
    always_comb begin
        do_rise  = 1'b0;
        do_fall  = 1'b0;
        do_apply = 1'b0;
        do_load  = 1'b0;
        do_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                do_apply = pending;
                do_rise  = i_enable;
                do_load  = i_enable;
            end
            ST_RUN: begin
                if (cnt_nonzero) begin
                    do_dec = 1'b1;
                end else if (o_clk) begin
                    do_fall = 1'b1;
                    do_load = 1'b1;
                end else begin
                    do_apply = pending;
                    do_rise  = i_enable;
                    do_load  = i_enable;
                end
            end
            default: begin
                do_rise = 1'b0;
            end
        endcase
    end

    // Counter, divisor registers and registered clock/strobes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt         <= '0;
            active_div  <= RESET_DIV;
            pending_div <= '0;
            pending     <= 1'b0;
            o_clk       <= 1'b0;
            o_rise      <= 1'b0;
            o_fall      <= 1'b0;
        end else begin
            if (do_load) begin
                cnt <= load_value;
            end else if (do_dec) begin
                cnt <= cnt - CNT_ONE;
            end

            if (do_apply) begin
                active_div <= pending_div;
            end

            // accept needs pending==0 and apply needs pending==1: never both
            if (accept) begin
                pending_div <= i_div;
                pending     <= 1'b1;
            end else if (do_apply) begin
                pending     <= 1'b0;
            end

            if (do_rise) begin
                o_clk <= 1'b1;
            end else if (do_fall) begin
                o_clk <= 1'b0;
            end

            o_rise <= do_rise;
            o_fall <= do_fall;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gen_ctrl
// Brief    : Scenario tests plus randomized run of clock_gen_ctrl against a
//            phase-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gen_ctrl;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_enable = 1'b0;
    logic [W-1:0] i_div = '0;
    logic         i_div_valid = 1'b0;
    logic         o_div_ready;
    logic         o_clk;
    logic         o_rise;
    logic         o_fall;
    logic         o_running;

    clock_gen_ctrl #(
        .DIV_WIDTH  (W),
        .DEFAULT_DIV(2)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_div      (i_div),
        .i_div_valid(i_div_valid),
        .o_div_ready(o_div_ready),
        .o_clk      (o_clk),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_running  (o_running)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Phase-level model: level, cycles left in the current phase, divisors
    bit m_running, m_level, m_rise, m_fall, m_pending;
    int m_active, m_pdiv, m_left;

    logic [4:0] act;
    assign act = {o_clk, o_rise, o_fall, o_running, o_div_ready};

    function automatic logic [4:0] exp_vec();
        return {m_level, m_rise, m_fall, m_running, !m_pending};
    endfunction

    task automatic model_step();
        bit accept;
        if (i_reset) begin
            m_running = 0; m_level = 0; m_rise = 0; m_fall = 0;
            m_pending = 0; m_active = 2; m_left = 0;
            return;
        end
        accept = i_div_valid && !m_pending;
        m_rise = 0;
        m_fall = 0;
        if (!m_running) begin
            if (m_pending) begin m_active = m_pdiv; m_pending = 0; end
            if (i_enable) begin
                m_running = 1; m_level = 1; m_left = m_active + 1; m_rise = 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_level) begin
                    m_level = 0; m_left = m_active + 1; m_fall = 1;
                end else begin
                    if (m_pending) begin m_active = m_pdiv; m_pending = 0; end
                    if (i_enable) begin
                        m_level = 1; m_left = m_active + 1; m_rise = 1;
                    end else begin
                        m_running = 0;
                    end
                end
            end
        end
        if (accept) begin m_pending = 1; m_pdiv = int'(i_div); end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic measure_period(output int p);
        p = -1;
        for (int n = 0; n < 100 && o_rise !== 1'b1; n++) tick();
        if (o_rise !== 1'b1) return;
        for (int n = 1; n < 100; n++) begin
            tick();
            if (o_rise === 1'b1) begin p = n; return; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (o_running === 1'b0) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic load_div_idle(input int d);
        i_div = W'(d);
        i_div_valid = 1'b1;
        tick();
        i_div_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_enable = 1'b1; i_div = W'(7); i_div_valid = 1'b1;
        tick(); tick();
        total++;
        if (act !== 5'b00001) begin bad++; $display("FAIL reset_state: got %b want 00001", act); end
        i_reset = 1'b0; i_enable = 1'b0; i_div_valid = 1'b0;
        tick();
        total++;
        if (act !== 5'b00001) begin bad++; $display("FAIL reset_idle: got %b want 00001", act); end
    endtask

    task automatic test_default_period();
        bit [5:0] pat = 6'b000111;
        bit ok;
        i_enable = 1'b1;
        tick();
        for (int k = 0; k < 18; k++) begin
            total++;
            if (o_clk !== pat[k % 6]) begin bad++; $display("FAIL def_clk k=%0d: got %b want %b", k, o_clk, pat[k % 6]); end
            total++;
            if (o_rise !== (k % 6 == 0)) begin bad++; $display("FAIL def_rise k=%0d: got %b want %b", k, o_rise, (k % 6 == 0)); end
            total++;
            if (o_fall !== (k % 6 == 3)) begin bad++; $display("FAIL def_fall k=%0d: got %b want %b", k, o_fall, (k % 6 == 3)); end
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL def_model k=%0d: got %b want %b", k, act, exp_vec()); end
            tick();
        end
        i_enable = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok || act !== 5'b00001) begin bad++; $display("FAIL def_stop: got %b want 00001", act); end
    endtask

    task automatic test_div_zero();
        bit ok;
        i_div = '0; i_div_valid = 1'b1;
        tick();
        i_div_valid = 1'b0;
        total++;
        if (o_div_ready !== 1'b0) begin bad++; $display("FAIL dz_ready_low: got %b want 0", o_div_ready); end
        tick();
        total++;
        if (o_div_ready !== 1'b1) begin bad++; $display("FAIL dz_ready_back: got %b want 1", o_div_ready); end
        i_enable = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            total++;
            if (o_clk !== (k % 2 == 0)) begin bad++; $display("FAIL dz_clk k=%0d: got %b want %b", k, o_clk, (k % 2 == 0)); end
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL dz_model k=%0d: got %b want %b", k, act, exp_vec()); end
            tick();
        end
        i_enable = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL dz_stop: got running=%b want 0", o_running); end
    endtask

    task automatic test_midphase_update();
        bit ok;
        load_div_idle(2);
        i_enable = 1'b1;
        tick();                      // c0: rise
        tick();                      // c1: mid high phase
        i_div = W'(4); i_div_valid = 1'b1;
        tick();                      // c2: accepted
        i_div_valid = 1'b0;
        for (int k = 2; k <= 26; k++) begin
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL mid_model k=%0d: got %b want %b", k, act, exp_vec()); end
            if (k == 3) begin total++; if (o_fall !== 1'b1) begin bad++; $display("FAIL mid_fall_old: got %b want 1", o_fall); end end
            if (k == 5) begin total++; if (o_div_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_held: got %b want 0", o_div_ready); end end
            if (k == 6) begin
                total++;
                if ({o_rise, o_div_ready} !== 2'b11) begin bad++; $display("FAIL mid_boundary: got %b want 11", {o_rise, o_div_ready}); end
            end
            if (k == 11) begin total++; if (o_fall !== 1'b1) begin bad++; $display("FAIL mid_fall_new: got %b want 1", o_fall); end end
            if (k == 16) begin total++; if (o_rise !== 1'b1) begin bad++; $display("FAIL mid_rise_new: got %b want 1", o_rise); end end
            tick();
        end
        i_enable = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL mid_stop: got running=%b want 0", o_running); end
    endtask

    task automatic test_stop();
        int highs, runs, rises;
        load_div_idle(3);
        i_enable = 1'b1;
        tick();                      // c0: rise
        highs = int'(o_clk); runs = int'(o_running); rises = int'(o_rise);
        tick();                      // c1
        i_enable = 1'b0;
        for (int k = 1; k < 25; k++) begin
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL stop_model k=%0d: got %b want %b", k, act, exp_vec()); end
            highs += int'(o_clk); runs += int'(o_running); rises += int'(o_rise);
            tick();
        end
        total++;
        if (highs != 4) begin bad++; $display("FAIL stop_high_cycles: got %0d want 4", highs); end
        total++;
        if (runs != 8) begin bad++; $display("FAIL stop_run_cycles: got %0d want 8", runs); end
        total++;
        if (rises != 1) begin bad++; $display("FAIL stop_rises: got %0d want 1", rises); end
        total++;
        if ({o_clk, o_running} !== 2'b00) begin bad++; $display("FAIL stop_final: got %b want 00", {o_clk, o_running}); end
    endtask

    task automatic test_stop_pending();
        int p;
        bit ok;
        i_enable = 1'b1;
        tick();                      // c0: rise, active=3
        for (int k = 0; k < 5; k++) tick();   // c5: low phase
        i_div = W'(1); i_div_valid = 1'b1;
        tick();                      // c6
        i_div_valid = 1'b0; i_enable = 1'b0;
        tick(); tick();              // c8: boundary passed
        total++;
        if (act !== 5'b00001) begin bad++; $display("FAIL sp_idle: got %b want 00001", act); end
        total++;
        if (act !== exp_vec()) begin bad++; $display("FAIL sp_model: got %b want %b", act, exp_vec()); end
        tick(); tick();
        i_enable = 1'b1;
        measure_period(p);
        total++;
        if (p != 4) begin bad++; $display("FAIL sp_new_period: got %0d want 4", p); end
        i_enable = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL sp_stop: got running=%b want 0", o_running); end
    endtask

    task automatic test_reset_midphase();
        int p;
        bit ok;
        i_enable = 1'b1;
        tick();                      // c0: rise, active=1
        i_div = W'(5); i_div_valid = 1'b1;
        tick();                      // c1: pending
        i_div_valid = 1'b0; i_reset = 1'b1;
        tick();
        total++;
        if (act !== 5'b00001) begin bad++; $display("FAIL rm_reset: got %b want 00001", act); end
        i_reset = 1'b0;
        measure_period(p);
        total++;
        if (p != 6) begin bad++; $display("FAIL rm_period: got %0d want 6", p); end
        i_enable = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rm_stop: got running=%b want 0", o_running); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            i_reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) i_enable = ~i_enable;
            i_div_valid = ($urandom_range(0, 7) == 0);
            i_div = W'($urandom_range(0, 6));
            tick();
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL rand_model k=%0d: got %b want %b", k, act, exp_vec()); end
        end
        i_reset = 1'b0; i_enable = 1'b0; i_div_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_div_zero();
        test_midphase_update();
        test_stop();
        test_stop_pending();
        test_reset_midphase();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
